// File: rtl/writeback_stage.sv
// Y86 writeback stage: W pipeline register, paced register-file write strobes,
// status tracking and stop-on-fault. Define WB_FWD_EN to expose the W register for decode forwarding.
module writeback_stage #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_dstE,
  input  logic [31:0]      m_valE,
  input  logic [3:0]       m_dstM,
  input  logic [31:0]      m_valM,
  output logic             write1,
  output logic [3:0]       register1,
  output logic [31:0]      value1,
  output logic             write2,
  output logic [3:0]       register2,
  output logic [31:0]      value2,
  output logic [2:0]       stat,
  output logic             halted,
`ifdef WB_FWD_EN
  output logic             fwd_valid,
  output logic [3:0]       fwd_dstE,
  output logic [31:0]      fwd_valE,
  output logic [3:0]       fwd_dstM,
  output logic [31:0]      fwd_valM,
`endif
  output logic [CNT_W-1:0] retired
);

  localparam int          GAP_N    = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int          GW       = (GAP_N > 1) ? $clog2(GAP_N) : 1;
  localparam logic [2:0]  STAT_AOK = 3'd1;
  localparam logic [3:0]  REG_NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_STOPPED} state_t;

  state_t        r_state;
  logic [GW-1:0] r_gap;
  logic [2:0]    r_stat;

  logic w_accept;
  logic w_m_aok;
  logic w_m_conflict;

  assign m_ready      = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap == '0));
  assign w_accept     = m_valid & m_ready;
  assign w_m_aok      = (m_stat == STAT_AOK);
  assign w_m_conflict = (m_dstE == m_dstM) && (m_dstE != REG_NONE);

  // The W register's data fields are the port register/value outputs themselves; they
  // load only on an AOK accept so the ports keep the last written values otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_stat    <= STAT_AOK;
      write1    <= 1'b0;
      write2    <= 1'b0;
      register1 <= REG_NONE;
      register2 <= REG_NONE;
      value1    <= '0;
      value2    <= '0;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      write1 <= 1'b0;
      write2 <= 1'b0;
      if (w_accept) begin
        r_stat <= m_stat;
        if (w_m_aok) begin
          write1    <= (m_dstE != REG_NONE) && !w_m_conflict;
          write2    <= (m_dstM != REG_NONE);
          register1 <= m_dstE;
          value1    <= m_valE;
          register2 <= m_dstM;
          value2    <= m_valM;
        end
      end
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_WRITE;
        S_WRITE: begin
          if (r_stat != STAT_AOK) begin
            r_state <= S_STOPPED;
            stat    <= r_stat;
            halted  <= 1'b1;
          end else begin
            retired <= retired + CNT_W'(1);
            r_state <= S_GAP;
            r_gap   <= GW'(GAP_N - 1);
          end
        end
        S_GAP: begin
          if (r_gap == '0) r_state <= w_accept ? S_WRITE : S_IDLE;
          else             r_gap   <= r_gap - GW'(1);
        end
        S_STOPPED: r_state <= S_STOPPED;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  logic w_w_aok;
  assign w_w_aok   = (r_stat == STAT_AOK);
  assign fwd_valid = (r_state == S_WRITE);
  assign fwd_dstE  = (!w_w_aok || ((register1 == register2) && (register1 != REG_NONE)))
                     ? REG_NONE : register1;
  assign fwd_valE  = value1;
  assign fwd_dstM  = w_w_aok ? register2 : REG_NONE;
  assign fwd_valM  = value2;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: scoreboard of expected register-file writes plus
// per-scenario checks of pacing, conflicts, halting, reset abort and counter wrap.
module tb_writeback_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [2:0]  m_stat;
  logic [3:0]  m_dstE, m_dstM;
  logic [31:0] m_valE, m_valM;

  logic        m_ready, write1, write2, halted;
  logic [3:0]  register1, register2;
  logic [31:0] value1, value2;
  logic [2:0]  stat;
  logic [31:0] retired;

  logic        b_ready, b_w1, b_w2, b_halted;
  logic [3:0]  b_r1, b_r2;
  logic [31:0] b_v1, b_v2;
  logic [2:0]  b_stat;
  logic [3:0]  retired4;

`ifdef WB_FWD_EN
  logic        f_valid, bf_valid;
  logic [3:0]  f_dstE, f_dstM, bf_dstE, bf_dstM;
  logic [31:0] f_valE, f_valM, bf_valE, bf_valM;
`endif

  writeback_stage #(.GAP_CYCLES(1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .m_valid(m_valid), .m_ready(m_ready),
    .m_stat(m_stat), .m_dstE(m_dstE), .m_valE(m_valE), .m_dstM(m_dstM), .m_valM(m_valM),
    .write1(write1), .register1(register1), .value1(value1),
    .write2(write2), .register2(register2), .value2(value2),
    .stat(stat), .halted(halted),
`ifdef WB_FWD_EN
    .fwd_valid(f_valid), .fwd_dstE(f_dstE), .fwd_valE(f_valE), .fwd_dstM(f_dstM), .fwd_valM(f_valM),
`endif
    .retired(retired)
  );

  writeback_stage #(.GAP_CYCLES(1), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .m_valid(m_valid), .m_ready(b_ready),
    .m_stat(m_stat), .m_dstE(m_dstE), .m_valE(m_valE), .m_dstM(m_dstM), .m_valM(m_valM),
    .write1(b_w1), .register1(b_r1), .value1(b_v1),
    .write2(b_w2), .register2(b_r2), .value2(b_v2),
    .stat(b_stat), .halted(b_halted),
`ifdef WB_FWD_EN
    .fwd_valid(bf_valid), .fwd_dstE(bf_dstE), .fwd_valE(bf_valE), .fwd_dstM(bf_dstM), .fwd_valM(bf_valM),
`endif
    .retired(retired4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        w1, w2;
    logic [3:0]  r1, r2;
    logic [31:0] v1, v2;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_ret = 0;
  logic        prev_strobe = 1'b0;
  time         acc_time[$];

  // Monitor: every strobe cycle must match the oldest expected write and never follow another.
  always @(negedge clock) begin
    logic strobe;
    exp_t e;
    strobe = (write1 === 1'b1) || (write2 === 1'b1);
    if (strobe) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got w1=%b r1=%h v1=%h w2=%b r2=%h v2=%h, want no write",
                 write1, register1, value1, write2, register2, value2);
      end else begin
        e = q.pop_front();
        if ({write1, register1, value1, write2, register2, value2} !==
            {e.w1, e.r1, e.v1, e.w2, e.r2, e.v2}) begin
          n_fail++;
          $display("FAIL write_data got w1=%b r1=%h v1=%h w2=%b r2=%h v2=%h, want w1=%b r1=%h v1=%h w2=%b r2=%h v2=%h",
                   write1, register1, value1, write2, register2, value2,
                   e.w1, e.r1, e.v1, e.w2, e.r2, e.v2);
        end
      end
      n_tests++;
      if (prev_strobe) begin
        n_fail++;
        $display("FAIL strobe_gap got strobe high on two consecutive cycles, want a low cycle between");
      end
    end
    prev_strobe = strobe;
  end

  task automatic do_reset();
    m_valid = 1'b0; m_stat = 3'd1; m_dstE = 4'hF; m_dstM = 4'hF; m_valE = '0; m_valM = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    acc_time.delete();
    exp_ret = 0;
  endtask

  task automatic send(input logic [2:0] s, input logic [3:0] de, input logic [31:0] ve,
                      input logic [3:0] dm, input logic [31:0] vm);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    m_valid = 1'b1; m_stat = s; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (m_ready === 1'b1) begin
        ok = 1'b1;
        if (s == 3'd1) begin
          exp_ret++;
          e.w1 = (de != 4'hF) && (de != dm);
          e.w2 = (dm != 4'hF);
          e.r1 = de; e.v1 = ve; e.r2 = dm; e.v2 = vm;
          if (e.w1 || e.w2) q.push_back(e);
        end
      end
      @(posedge clock);
      if (ok) acc_time.push_back($time);
      #1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout got m_ready=%b for 20 cycles, want 1", m_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d writes outstanding, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({write1, write2, register1, register2, value1, value2, stat, halted, m_ready} !==
        {1'b0, 1'b0, 4'hF, 4'hF, 32'h0, 32'h0, 3'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs got w1=%b w2=%b r1=%h r2=%h v1=%h v2=%h stat=%0d halted=%b ready=%b, want 0 0 f f 0 0 1 0 1",
               write1, write2, register1, register2, value1, value2, stat, halted, m_ready);
    end
    n_tests++;
    if (retired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_retired got %0d want 0", retired);
    end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    send(3'd1, 4'h0, 32'h5, 4'hF, 32'h0);
    m_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({write1, register1, value1, write2, m_ready} !== {1'b1, 4'h0, 32'h5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_write got w1=%b r1=%h v1=%h w2=%b ready=%b, want 1 0 5 0 0",
               write1, register1, value1, write2, m_ready);
    end
    @(negedge clock);
    n_tests++;
    if ({write1, m_ready, retired} !== {1'b0, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL single_after got w1=%b ready=%b retired=%0d, want 0 1 1", write1, m_ready, retired);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) send(3'd1, 4'(i + 1), 32'h100 + 32'(i), 4'(i + 8), 32'h200 + 32'(i));
    m_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (acc_time[i] - acc_time[i-1] != 20) begin
        n_fail++;
        $display("FAIL b2b_spacing got %0t want 20 between accepts %0d and %0d",
                 acc_time[i] - acc_time[i-1], i - 1, i);
      end
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (retired !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_retired got %0d want 4", retired);
    end
    drain();
  endtask

  task automatic test_conflict();
    do_reset();
    send(3'd1, 4'h4, 32'h1, 4'h4, 32'h2);
    m_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({write1, write2, register2, value2} !== {1'b0, 1'b1, 4'h4, 32'h2}) begin
      n_fail++;
      $display("FAIL conflict got w1=%b w2=%b r2=%h v2=%h, want 0 1 4 2", write1, write2, register2, value2);
    end
    drain();
  endtask

  task automatic test_halt();
    do_reset();
    send(3'd1, 4'h1, 32'h11, 4'hF, 32'h0);
    send(3'd2, 4'h2, 32'h22, 4'hF, 32'h0);
    m_valid = 1'b1; m_stat = 3'd1; m_dstE = 4'h3; m_valE = 32'h33; m_dstM = 4'h5; m_valM = 32'h55;
    repeat (10) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({stat, halted, m_ready, retired} !== {3'd2, 1'b1, 1'b0, 32'd1}) begin
      n_fail++;
      $display("FAIL halt_state got stat=%0d halted=%b ready=%b retired=%0d, want 2 1 0 1",
               stat, halted, m_ready, retired);
    end
    m_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send(3'd1, 4'h3, 32'h9, 4'hF, 32'h0);
    m_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({write1, write2, stat, retired, register1, m_ready} !== {1'b0, 1'b0, 3'd1, 32'd0, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_abort got w1=%b w2=%b stat=%0d retired=%0d r1=%h ready=%b, want 0 0 1 0 f 1",
               write1, write2, stat, retired, register1, m_ready);
    end
    #1 reset = 1'b0;
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) send(3'd1, 4'h5, 32'(i), 4'hF, 32'h0);
    m_valid = 1'b0;
    drain();
    n_tests++;
    if (retired4 !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_cnt4 got %0d want 1", retired4);
    end
    n_tests++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL wrap_cnt32 got %0d want %0d", retired, exp_ret);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_conflict();
    test_halt();
    test_reset_mid_write();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got simulation still running, want completion");
    $fatal(1, "timeout");
  end

endmodule
